// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory request/ready bus between the MEM stage (master)
//               and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
  parameter int AW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Issues loads/stores on a req/ready memory
//               bus with variable wait states and a timeout, stalls upstream
//               while an access is outstanding, and owns the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ADDR_BASE = 1024,
  parameter int AW        = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res_MEM,
  input  logic [31:0] rm_val_MEM,
  input  logic [3:0]  dest_MEM,
  input  logic        WB_EN_MEM,
  input  logic        MEM_R_EN_MEM,
  input  logic        MEM_W_EN_MEM,
  mem_stage_if.master mem,
  output logic        freeze,
  output logic        mem_err,
  output logic [31:0] alu_res_WB,
  output logic [31:0] mem_res_WB,
  output logic [3:0]  dest_WB,
  output logic        WB_EN_WB,
  output logic        MEM_R_EN_WB
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     buf_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic            access;
  logic            last_busy;
  logic [AW-1:0]   addr_word;

  assign access = MEM_R_EN_MEM | MEM_W_EN_MEM;

  // The counter holds the number of BUSY cycles already spent, so the
  // TIMEOUT-th BUSY cycle is the last one before the access is abandoned.
  assign last_busy = (cnt_q == CW'(TIMEOUT - 1));

  // Byte address relative to the window base (32-bit wrap), then word index.
  assign addr_word = AW'((alu_res_MEM - 32'(ADDR_BASE)) >> 2);

  // Stall everything upstream until the access reaches DONE.
  assign freeze = access & (state_q != DONE);

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; ready takes priority over the timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = BUSY;
      BUSY:    if (mem.mem_ready || last_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access datapath: latch the request on IDLE->BUSY, count wait states,
  // capture read data or zero it on timeout, and keep the sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mem_err <= 1'b0;
    end else begin
      if (state_q == IDLE && access) begin
        cnt_q   <= '0;
        addr_q  <= addr_word;
        we_q    <= MEM_W_EN_MEM;
        wdata_q <= rm_val_MEM;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
        if (mem.mem_ready) begin
          buf_q <= mem.mem_rdata;
        end else if (last_busy) begin
          buf_q   <= '0;
          mem_err <= 1'b1;
        end
      end
    end
  end

  // MEM/WB register: pass-through for ALU ops, bubbles while an access is
  // pending, and the completed access in DONE (stores never select mem_res).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_WB  <= '0;
      mem_res_WB  <= '0;
      dest_WB     <= '0;
      WB_EN_WB    <= 1'b0;
      MEM_R_EN_WB <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            alu_res_WB  <= '0;
            mem_res_WB  <= '0;
            dest_WB     <= '0;
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
          end else begin
            alu_res_WB  <= alu_res_MEM;
            mem_res_WB  <= '0;
            dest_WB     <= dest_MEM;
            WB_EN_WB    <= WB_EN_MEM;
            MEM_R_EN_WB <= 1'b0;
          end
        end
        DONE: begin
          alu_res_WB  <= alu_res_MEM;
          mem_res_WB  <= buf_q;
          dest_WB     <= dest_MEM;
          WB_EN_WB    <= WB_EN_MEM;
          MEM_R_EN_WB <= MEM_R_EN_MEM & ~MEM_W_EN_MEM;
        end
        default: begin
          alu_res_WB  <= '0;
          mem_res_WB  <= '0;
          dest_WB     <= '0;
          WB_EN_WB    <= 1'b0;
          MEM_R_EN_WB <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
